// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector into a combinational block and checks it against TABLE.
// Optional macro STOP_ON_FAIL_EN ends the sweep on the first mismatch and holds the failing vector on dut_in.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] TABLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic [N_IN-1:0]  vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic             fail_seen
);

    localparam int NV = 2 ** N_IN;
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

    state_t               state_reg, state_next;
    logic                 start_reg, rise_reg;
    logic [N_IN-1:0]      vec_reg;
    logic [N_IN:0]        err_reg;
    logic [N_IN-1:0]      ff_reg;
    logic                 fs_reg;
    logic [CW-1:0]        cnt_reg;
    logic [N_OUT-1:0]     exp_tab [NV];
    logic                 match;
    logic                 last_vec;
    logic                 launch;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_tab
            assign exp_tab[gi] = TABLE[gi*N_OUT +: N_OUT];
        end
    endgenerate

    // XOR reduction rather than ==, so an X on dut_out falls into the mismatch branch.
    assign match    = ~|(dut_out ^ exp_tab[vec_reg]);
    assign last_vec = &vec_reg;
    assign launch   = rise_reg && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            start_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= start;
            rise_reg  <= start && !start_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (launch) state_next = APPLY;
            APPLY: state_next = (SETTLE > 0) ? WAIT : CHECK;
            WAIT:  if (cnt_reg == CW'(1)) state_next = CHECK;
            CHECK: begin
`ifdef STOP_ON_FAIL_EN
                if (match) state_next = last_vec ? DONE : APPLY;
                else       state_next = DONE;
`else
                state_next = last_vec ? DONE : APPLY;
`endif
            end
            DONE:  if (launch) state_next = APPLY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_reg <= '0;
            err_reg <= '0;
            ff_reg  <= '0;
            fs_reg  <= 1'b0;
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (launch) begin
                        vec_reg <= '0;
                        err_reg <= '0;
                        ff_reg  <= '0;
                        fs_reg  <= 1'b0;
                    end
                end
                APPLY: cnt_reg <= CW'(SETTLE);
                WAIT:  cnt_reg <= cnt_reg - CW'(1);
                CHECK: begin
                    if (match) begin
                        err_reg <= err_reg;
                    end else begin
                        err_reg <= err_reg + (N_IN+1)'(1);
                        if (!fs_reg) begin
                            ff_reg <= vec_reg;
                            fs_reg <= 1'b1;
                        end
                    end
`ifdef STOP_ON_FAIL_EN
                    if (match && !last_vec) vec_reg <= vec_reg + N_IN'(1);
`else
                    if (!last_vec) vec_reg <= vec_reg + N_IN'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == APPLY) || (state_reg == WAIT) || (state_reg == CHECK);
        done = (state_reg == DONE);
        pass = (state_reg == DONE) && (err_reg == '0);
    end

    assign dut_in         = vec_reg;
    assign vec_idx        = vec_reg;
    assign err_count      = err_reg;
    assign first_fail_idx = ff_reg;
    assign fail_seen      = fs_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three configurations driving faultable behavioural DUTs, checked against a sweep-level model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [31:0] add_tab();
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i*2 +: 2] = 2'((i / 4) + (i % 4));
        return t;
    endfunction

    localparam logic [7:0]  MAJ_TABLE = 8'b11101000;
    localparam logic [31:0] ADD_TABLE = add_tab();

    // A: majority, SETTLE=1.  B: majority, SETTLE=0.  C: 2-bit adder, SETTLE=2.
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [7:0] bad_a = '0, bad_b = '0;
    logic [1:0] flip_c [16];
    logic [2:0] din_a, din_b, vi_a, vi_b, ff_a, ff_b;
    logic [3:0] din_c, vi_c, ff_c, err_a, err_b;
    logic [4:0] err_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic pass_a, pass_b, pass_c, fs_a, fs_b, fs_c;
    logic out_a, out_b;
    logic [1:0] out_c;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign out_a = maj(din_a) ^ bad_a[din_a];
    assign out_b = maj(din_b) ^ bad_b[din_b];
    assign out_c = 2'(din_c[3:2] + din_c[1:0]) ^ flip_c[din_c];

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1), .TABLE(MAJ_TABLE)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_out(out_a), .dut_in(din_a), .vec_idx(vi_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_idx(ff_a), .fail_seen(fs_a));
    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(0), .TABLE(MAJ_TABLE)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_out(out_b), .dut_in(din_b), .vec_idx(vi_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail_idx(ff_b), .fail_seen(fs_b));
    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(2), .TABLE(ADD_TABLE)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .dut_out(out_c), .dut_in(din_c), .vec_idx(vi_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail_idx(ff_c), .fail_seen(fs_c));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic sample(input int inst, output logic d, output logic b, output logic p, output logic fs,
                          output int err, output int ff, output int din, output int vi);
        case (inst)
            0: begin d = done_a; b = busy_a; p = pass_a; fs = fs_a; err = err_a; ff = ff_a; din = din_a; vi = vi_a; end
            1: begin d = done_b; b = busy_b; p = pass_b; fs = fs_b; err = err_b; ff = ff_b; din = din_b; vi = vi_b; end
            default: begin d = done_c; b = busy_c; p = pass_c; fs = fs_c; err = err_c; ff = ff_c; din = din_c; vi = vi_c; end
        endcase
    endtask

    // Sweep-level model: faulty vectors are the set bits of bad; timing is vectors * (settle + 2) plus one.
    task automatic ref_model(input int nv, input int s, input logic [15:0] bad,
                             output int e_err, output int e_ff, output int e_lat, output int e_idx);
        int first;
        e_err = 0;
        first = -1;
        for (int i = 0; i < nv; i++) begin
            if (bad[i]) begin
                e_err++;
                if (first < 0) first = i;
            end
        end
        e_ff  = (first < 0) ? 0 : first;
        e_lat = nv * (s + 2) + 1;
        e_idx = nv - 1;
`ifdef STOP_ON_FAIL_EN
        if (first >= 0) begin
            e_err = 1;
            e_lat = (first + 1) * (s + 2) + 1;
            e_idx = first;
        end
`endif
    endtask

    task automatic run_sweep(input int inst, input logic [15:0] bad_in, input bit toggle, input string name);
        int nv, s, cycles, e_err, e_ff, e_lat, e_idx, err, ff, din, vi;
        logic d, b, p, fs;
        logic [15:0] bad;
        bit timed_out;
        case (inst)
            0: begin nv = 8; s = 1; end
            1: begin nv = 8; s = 0; end
            default: begin nv = 16; s = 2; end
        endcase
        bad = (nv == 8) ? {8'h00, bad_in[7:0]} : bad_in;
        case (inst)
            0: bad_a = bad[7:0];
            1: bad_b = bad[7:0];
            default: for (int i = 0; i < 16; i++) flip_c[i] = bad[i] ? 2'($urandom_range(1, 3)) : 2'b00;
        endcase
        ref_model(nv, s, bad, e_err, e_ff, e_lat, e_idx);

        @(negedge clk);
        set_start(inst, 1'b1);
        cycles = 0;
        timed_out = 1'b0;
        while (1) begin
            @(posedge clk);
            cycles++;
            #1;
            if (toggle && cycles == 6) set_start(inst, 1'b0);
            if (toggle && cycles == 8) set_start(inst, 1'b1);
            sample(inst, d, b, p, fs, err, ff, din, vi);
            if (d && cycles > 1) break;
            if (cycles > 1000) begin timed_out = 1'b1; break; end
        end
        if (timed_out) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done never rose within %0d cycles", name, cycles);
        end
        check({name, "_latency"}, cycles - 1, e_lat);
        check({name, "_err"}, err, e_err);
        check({name, "_first"}, ff, e_ff);
        check({name, "_pass"}, p, (e_err == 0) ? 1 : 0);
        check({name, "_failseen"}, fs, (e_err > 0) ? 1 : 0);
        check({name, "_busy"}, b, 0);
        check({name, "_dutin"}, din, e_idx);
        check({name, "_vecidx"}, vi, e_idx);
        $display("[TB] %s inst=%0d bad=%h err=%0d first=%0d latency=%0d", name, inst, bad, err, ff, cycles - 1);

        // start still high: results must stay frozen in DONE
        repeat (4) @(posedge clk);
        #1;
        sample(inst, d, b, p, fs, err, ff, din, vi);
        check({name, "_hold_done"}, d, 1);
        check({name, "_hold_err"}, err, e_err);
        check({name, "_hold_dutin"}, din, e_idx);
        @(negedge clk);
        set_start(inst, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int          inst;
        logic [15:0] bad;
        bit          toggle;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        logic d, b, p, fs;
        int err, ff, din, vi, inst;
        logic [15:0] bad;

        for (int i = 0; i < 16; i++) flip_c[i] = 2'b00;
        vecs[0] = '{inst: 0, bad: 16'h0000, toggle: 1'b0};   // clean majority
        vecs[1] = '{inst: 0, bad: 16'h0020, toggle: 1'b0};   // vector 5 forced to 0
        vecs[2] = '{inst: 1, bad: 16'h00FF, toggle: 1'b0};   // SETTLE=0, all inverted
        vecs[3] = '{inst: 2, bad: 16'h0000, toggle: 1'b0};   // clean adder
        vecs[4] = '{inst: 2, bad: 16'h8421, toggle: 1'b0};
        vecs[5] = '{inst: 0, bad: 16'h0000, toggle: 1'b1};   // start re-edged mid-sweep

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        sample(0, d, b, p, fs, err, ff, din, vi);
        check("reset_busy", b, 0);
        check("reset_done", d, 0);
        check("reset_pass", p, 0);
        check("reset_err", err, 0);
        check("reset_dutin", din, 0);
        check("reset_failseen", fs, 0);

        for (int i = 0; i < 6; i++) run_sweep(vecs[i].inst, vecs[i].bad, vecs[i].toggle, $sformatf("vec%0d", i));

        // Reset in the middle of vector 4, then a clean sweep.
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        while (din_a != 3'd4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset_reached4", din_a, 4);
        bad_a = 8'h01;
        reset = 1'b1;
        start_a = 1'b0;
        @(posedge clk);
        #1;
        sample(0, d, b, p, fs, err, ff, din, vi);
        check("midreset_busy", b, 0);
        check("midreset_done", d, 0);
        check("midreset_err", err, 0);
        check("midreset_dutin", din, 0);
        check("midreset_failseen", fs, 0);
        @(negedge clk);
        reset = 1'b0;
        run_sweep(0, 16'h0000, 1'b0, "after_reset");

        for (int r = 0; r < 10; r++) begin
            inst = $urandom_range(0, 2);
            bad = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            run_sweep(inst, bad, 1'b0, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
